led_game_ctrl: RTL and testbench
================================

# led_game_ctrl

Round sequencer for the LED pattern-memory game. Each round it shows a pseudo-random pattern on the LEDs, blanks them and runs the 3-second countdown timer, then collects the player's switch entry and scores it. It sits between the board I/O (buttons, switches, LEDs) and the countdown timer. It owns the timer's reset and start, and it consumes the timer's `next_stage`.

## Interface
- `LED_W`, 8: pattern / LED / switch width (1..16)
- `SHOW_CYCLES`, 1000000: clocks the pattern stays lit (1 s at 1 MHz); must be ≥1
- `MAX_LEVEL`, 9: rounds to clear before win (1..15)
- `TIMEOUT_CYCLES`, 10000000: input-phase limit, used only with `INPUT_TIMEOUT_EN`
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset; one clock domain
- `btn_start`  in  1  single-cycle pulse (debounced upstream); starts a game
- `btn_submit`  in  1  single-cycle pulse; commits `sw`
- `sw`  in  LED_W  player entry
- `next_stage`  in  1  from timer; level, high when countdown finished
- `timer_rst_n`  out  1  active-low reset to timer
- `start_countdown`  out  1  to timer
- `led`  out  LED_W  LED drive
- `level`  out  4  current round, 1-based
- `score`  out  4  rounds passed
- `pass_flag`, `fail_flag`  out  1  one-cycle result pulses
- `game_over`  out  1  level, high in OVER/WIN
- `win`  out  1  level, high in WIN

## Operation
- States: IDLE, SHOW, ARM, COUNT, INPUT, CHECK, OVER, WIN.
- IDLE:
  - `led`=0 and the LFSR free-runs every clock.
  - On `btn_start`: `level`←1, `score`←0, latch the pattern, go to SHOW.
- SHOW:
  - `led`=pattern for exactly SHOW_CYCLES clocks.
  - Then go to ARM.
- ARM:
  - One cycle with `timer_rst_n`=0. This forces the timer back to its idle state.
  - Then go to COUNT.
- COUNT:
  - `led`=0 and `start_countdown`=1 (held).
  - When `next_stage`=1 is sampled: drop `start_countdown` and go to INPUT.
- INPUT:
  - `led` mirrors `sw`.
  - On `btn_submit`: latch `sw` and go to CHECK.
- CHECK (one cycle), latched `sw` compared with the pattern:
  - Match, `level`<MAX_LEVEL: pulse `pass_flag`, `score`+1, `level`+1, step the LFSR once, latch the new pattern, go to SHOW.
  - Match, `level`=MAX_LEVEL: pulse `pass_flag`, `score`+1, go to WIN.
  - Mismatch: pulse `fail_flag`, go to OVER.
- OVER / WIN:
  - `game_over`=1; `win`=1 in WIN only.
  - `led`=pattern (OVER) or all-ones (WIN).
  - `btn_start` restarts the game as it does from IDLE.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, reset seed 16'hACE1.
  - Pattern = low LED_W bits; an all-zero slice is replaced by 1.
- `score` and `level` saturate at 15. Neither can wrap given MAX_LEVEL ≤15.
- `btn_start` outside IDLE/OVER/WIN is ignored. `btn_submit` outside INPUT is ignored.

## Timing
- Reset values:
  - state IDLE, LFSR 16'hACE1.
  - All outputs 0, except `timer_rst_n`=1.
- All outputs are registered. They change on the clock edge after the state transition.
- `btn_start` → first cycle of SHOW: 1 clock.
- SHOW → ARM: SHOW_CYCLES clocks after entry.
- `timer_rst_n` is low for exactly one clock per round.
- `start_countdown` first rises the clock after ARM.
- `next_stage` high → `start_countdown` low and INPUT entry: 1 clock.
- `btn_submit` → `pass_flag`/`fail_flag`: 2 clocks (INPUT→CHECK→pulse).
- `reset_n` asserted mid-round: immediate return to reset values, no pulse emitted.

## Configuration
- `LED_GAME_INPUT_TIMEOUT_EN` defined:
  - INPUT counts clocks from entry.
  - When TIMEOUT_CYCLES elapse without `btn_submit`: pulse `fail_flag`, go to OVER.
  - A `btn_submit` arriving in the same cycle as the timeout wins.
- Undefined: INPUT waits indefinitely, and no timeout counter is synthesised.

## Structure
- Package `led_game_pkg` holds:
  - the state enum;
  - LFSR seed and tap constants;
  - the level/score width (4).
- Sub-module `pattern_lfsr`, with ports `clk`, `reset_n`, `step`, `pattern`. The controller drives `step` every clock in IDLE and once in CHECK on a non-final pass.

## Test plan
1. Reset then check outputs: all 0, `timer_rst_n`=1, LFSR=16'hACE1.
2. SHOW_CYCLES=4, `btn_start`, then check SHOW/ARM timing:
   - `led`=pattern for 4 clocks;
   - `timer_rst_n` low 1 clock;
   - `start_countdown` high until the bench raises `next_stage`;
   - INPUT entered 1 clock later.
3. INPUT, `sw`=pattern, `btn_submit` → `pass_flag` 2 clocks later, `score`=1, `level`=2, new pattern shown.
4. INPUT, `sw`=pattern^1 → `fail_flag`, `game_over`=1, `led`=pattern; `btn_start` → `level`=1, `score`=0.
5. MAX_LEVEL=2, two correct rounds → `win`=1, `game_over`=1, `led`=all ones, `score`=2.
6. With `LED_GAME_INPUT_TIMEOUT_EN`, TIMEOUT_CYCLES=5, no submit → `fail_flag` after 5 clocks.
   - Repeat with submit on the 5th clock: pass takes priority.
   - Separately, `reset_n` low during COUNT → IDLE, no flags.

Source files
------------

// File: rtl/led_game_pkg.sv
// Shared types and constants for the LED pattern-memory game controller.
package led_game_pkg;

   // Round sequencer states
   typedef enum logic [2:0] {
      S_IDLE,
      S_SHOW,
      S_ARM,
      S_COUNT,
      S_INPUT,
      S_CHECK,
      S_OVER,
      S_WIN
   } game_state_t;

   // Level / score counters are 4 bits and saturate at 15
   localparam int LVL_W = 4;

   // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10)
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Saturating increment for level / score
   function automatic logic [LVL_W-1:0] sat_inc(input logic [LVL_W-1:0] v);
      return (v == {LVL_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/pattern_lfsr.sv
// Pattern generator: 16-bit Fibonacci LFSR (taps 16,14,13,11).
// `pattern` looks ahead: while `step` is high it shows the slice of the value
// the LFSR is about to land on, so a caller latching `pattern` on the same
// edge it steps gets the fresh pattern with no extra cycle.
// An all-zero slice is replaced by 1 so a round never shows a blank pattern.
module pattern_lfsr
   import led_game_pkg::*;
#(
   parameter int LED_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             step,
   output logic [LED_W-1:0] pattern
);

   logic [15:0]      lfsr_q;
   logic [15:0]      lfsr_nxt;
   logic             fb;
   logic [LED_W-1:0] slice;

   // Shift right, feedback into the MSB; LFSR_TAPS documents the tap set
   assign fb       = ^(lfsr_q & {10'b0, 6'b101101});
   assign lfsr_nxt = {fb, lfsr_q[15:1]};

   // LFSR state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) lfsr_q <= LFSR_SEED;
      else if (step) lfsr_q <= lfsr_nxt;
   end

   // Look-ahead slice with zero substitution
   always_comb begin
      slice   = step ? lfsr_nxt[LED_W-1:0] : lfsr_q[LED_W-1:0];
      pattern = (slice == '0) ? LED_W'(1) : slice;
   end

endmodule

// File: rtl/led_game_ctrl.sv
// LED pattern-memory game round sequencer.
// Shows a pattern, blanks and runs the external countdown timer, collects the
// switch entry and scores it. All outputs are registered.
// Optional: define LED_GAME_INPUT_TIMEOUT_EN to fail a round when no submit
// arrives within TIMEOUT_CYCLES clocks of entering INPUT.
module led_game_ctrl
   import led_game_pkg::*;
#(
   parameter int LED_W          = 8,
   parameter int SHOW_CYCLES    = 1000000,
   parameter int MAX_LEVEL      = 9,
   parameter int TIMEOUT_CYCLES = 10000000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             btn_start,
   input  logic             btn_submit,
   input  logic [LED_W-1:0] sw,
   input  logic             next_stage,
   output logic             timer_rst_n,
   output logic             start_countdown,
   output logic [LED_W-1:0] led,
   output logic [3:0]       level,
   output logic [3:0]       score,
   output logic             pass_flag,
   output logic             fail_flag,
   output logic             game_over,
   output logic             win
);

   localparam int SHOW_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
   localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(SHOW_CYCLES - 1);
   localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(MAX_LEVEL);

   game_state_t      state;
   logic [SHOW_W-1:0] show_cnt;
   logic [LED_W-1:0] pattern;
   logic [LED_W-1:0] pattern_r;
   logic [LED_W-1:0] sw_lat;
   logic             match;
   logic             step;

`ifdef LED_GAME_INPUT_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] to_cnt;
`endif

   assign match = (sw_lat == pattern_r);

   // LFSR free-runs in IDLE and advances once per non-final pass
   assign step = (state == S_IDLE) ||
                 ((state == S_CHECK) && match && (level < LVL_MAX));

   pattern_lfsr #(.LED_W(LED_W)) u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .step    (step),
      .pattern (pattern)
   );

   // Round FSM with registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= S_IDLE;
         show_cnt        <= '0;
         pattern_r       <= '0;
         sw_lat          <= '0;
         timer_rst_n     <= 1'b1;
         start_countdown <= 1'b0;
         led             <= '0;
         level           <= '0;
         score           <= '0;
         pass_flag       <= 1'b0;
         fail_flag       <= 1'b0;
         game_over       <= 1'b0;
         win             <= 1'b0;
`ifdef LED_GAME_INPUT_TIMEOUT_EN
         to_cnt          <= '0;
`endif
      end else begin
         pass_flag   <= 1'b0;
         fail_flag   <= 1'b0;
         timer_rst_n <= 1'b1;
         case (state)
            S_IDLE, S_OVER, S_WIN: begin
               if (btn_start) begin
                  level     <= LVL_W'(1);
                  score     <= '0;
                  pattern_r <= pattern;
                  led       <= pattern;
                  show_cnt  <= '0;
                  game_over <= 1'b0;
                  win       <= 1'b0;
                  state     <= S_SHOW;
               end
            end
            S_SHOW: begin
               if (show_cnt == SHOW_LAST) begin
                  timer_rst_n <= 1'b0;
                  led         <= '0;
                  state       <= S_ARM;
               end else begin
                  show_cnt <= show_cnt + 1'b1;
               end
            end
            S_ARM: begin
               start_countdown <= 1'b1;
               state           <= S_COUNT;
            end
            S_COUNT: begin
               if (next_stage) begin
                  start_countdown <= 1'b0;
                  led             <= sw;
                  state           <= S_INPUT;
`ifdef LED_GAME_INPUT_TIMEOUT_EN
                  to_cnt          <= '0;
`endif
               end
            end
            S_INPUT: begin
               led <= sw;
               if (btn_submit) begin
                  sw_lat <= sw;
                  state  <= S_CHECK;
               end
`ifdef LED_GAME_INPUT_TIMEOUT_EN
               else if (to_cnt == TO_LAST) begin
                  fail_flag <= 1'b1;
                  game_over <= 1'b1;
                  led       <= pattern_r;
                  state     <= S_OVER;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            S_CHECK: begin
               if (match) begin
                  pass_flag <= 1'b1;
                  score     <= sat_inc(score);
                  if (level < LVL_MAX) begin
                     level     <= sat_inc(level);
                     pattern_r <= pattern;
                     led       <= pattern;
                     show_cnt  <= '0;
                     state     <= S_SHOW;
                  end else begin
                     game_over <= 1'b1;
                     win       <= 1'b1;
                     led       <= '1;
                     state     <= S_WIN;
                  end
               end else begin
                  fail_flag <= 1'b1;
                  game_over <= 1'b1;
                  led       <= pattern_r;
                  state     <= S_OVER;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_led_game_ctrl.sv
// Directed bench for led_game_ctrl: SHOW_CYCLES=4, MAX_LEVEL=2, TIMEOUT_CYCLES=5.
module tb_led_game_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       btn_start, btn_submit, next_stage;
   logic [7:0] sw;
   logic       timer_rst_n, start_countdown;
   logic [7:0] led;
   logic [3:0] level, score;
   logic       pass_flag, fail_flag, game_over, win;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] m_lfsr;
   logic [7:0]  pat;

   led_game_ctrl #(
      .LED_W(8), .SHOW_CYCLES(4), .MAX_LEVEL(2), .TIMEOUT_CYCLES(5)
   ) dut (
      .clk(clk), .reset_n(reset_n), .btn_start(btn_start), .btn_submit(btn_submit),
      .sw(sw), .next_stage(next_stage), .timer_rst_n(timer_rst_n),
      .start_countdown(start_countdown), .led(led), .level(level), .score(score),
      .pass_flag(pass_flag), .fail_flag(fail_flag), .game_over(game_over), .win(win)
   );

   always #5 clk = ~clk;

   // Reference LFSR: Galois-free shift form, bit = x ^ x>>2 ^ x>>3 ^ x>>5
   function automatic logic [15:0] lfsr_step(input logic [15:0] x);
      logic [15:0] b;
      b = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 16'h0001;
      return (x >> 1) | (b << 15);
   endfunction

   function automatic logic [7:0] lfsr_pat(input logic [15:0] x);
      logic [7:0] s;
      s = x[7:0];
      return (s == 8'h00) ? 8'h01 : s;
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From the first SHOW cycle through to the first INPUT cycle
   task automatic show_to_input(input logic [7:0] p);
      for (int i = 0; i < 4; i++) begin
         check("show_led", 32'(led), 32'(p));
         check("show_trst", 32'(timer_rst_n), 32'd1);
         tick();
      end
      check("arm_trst", 32'(timer_rst_n), 32'd0);
      check("arm_led", 32'(led), 32'd0);
      check("arm_start", 32'(start_countdown), 32'd0);
      tick();
      check("cnt_trst", 32'(timer_rst_n), 32'd1);
      check("cnt_start", 32'(start_countdown), 32'd1);
      tick();
      tick();
      check("cnt_hold", 32'(start_countdown), 32'd1);
      next_stage = 1'b1;
      tick();
      next_stage = 1'b0;
      check("in_start", 32'(start_countdown), 32'd0);
      check("in_led", 32'(led), 32'(sw));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_led"}, 32'(led), 32'd0);
      check({tag, "_trst"}, 32'(timer_rst_n), 32'd1);
      check({tag, "_flags"}, {26'd0, start_countdown, pass_flag, fail_flag, game_over, win, 1'b0}, 32'd0);
      check({tag, "_lvl"}, {24'd0, level, score}, 32'd0);
   endtask

   initial begin
      reset_n = 1'b0; btn_start = 1'b0; btn_submit = 1'b0; next_stage = 1'b0; sw = 8'h00;
      tick(); tick();
      // 1: reset state
      check_reset_outputs("rst");
      check("rst_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'hACE1);
      reset_n = 1'b1;
      m_lfsr = 16'hACE1;

      // 2: idle free-run, start, SHOW/ARM/COUNT timing
      for (int i = 0; i < 3; i++) begin
         tick();
         m_lfsr = lfsr_step(m_lfsr);
         check("idle_led", 32'(led), 32'd0);
      end
      btn_start = 1'b1;
      tick();
      btn_start = 1'b0;
      m_lfsr = lfsr_step(m_lfsr);
      pat = lfsr_pat(m_lfsr);
      check("start_lvl", 32'(level), 32'd1);
      check("start_score", 32'(score), 32'd0);
      sw = pat;
      show_to_input(pat);

      // 3: correct entry -> pass two clocks after submit, next round shown
      btn_submit = 1'b1;
      tick();
      btn_submit = 1'b0;
      check("chk_pass_early", 32'(pass_flag), 32'd0);
      tick();
      check("pass_flag", 32'(pass_flag), 32'd1);
      check("pass_score", 32'(score), 32'd1);
      check("pass_level", 32'(level), 32'd2);
      m_lfsr = lfsr_step(m_lfsr);
      pat = lfsr_pat(m_lfsr);
      check("pass_newpat", 32'(led), 32'(pat));
      sw = pat ^ 8'h01;
      show_to_input(pat);

      // 4: wrong entry -> fail, OVER shows pattern; restart
      btn_submit = 1'b1;
      tick();
      btn_submit = 1'b0;
      tick();
      check("fail_flag", 32'(fail_flag), 32'd1);
      check("fail_pass", 32'(pass_flag), 32'd0);
      check("over_go", 32'(game_over), 32'd1);
      check("over_win", 32'(win), 32'd0);
      check("over_led", 32'(led), 32'(pat));
      tick();
      check("fail_pulse", 32'(fail_flag), 32'd0);
      btn_start = 1'b1;
      tick();
      btn_start = 1'b0;
      pat = lfsr_pat(m_lfsr);
      check("restart_lvl", 32'(level), 32'd1);
      check("restart_score", 32'(score), 32'd0);
      check("restart_go", 32'(game_over), 32'd0);

      // 5: two correct rounds -> WIN
      sw = pat;
      show_to_input(pat);
      btn_submit = 1'b1;
      tick();
      btn_submit = 1'b0;
      tick();
      m_lfsr = lfsr_step(m_lfsr);
      pat = lfsr_pat(m_lfsr);
      sw = pat;
      show_to_input(pat);
      btn_submit = 1'b1;
      tick();
      btn_submit = 1'b0;
      tick();
      check("win_pass", 32'(pass_flag), 32'd1);
      check("win_win", 32'(win), 32'd1);
      check("win_go", 32'(game_over), 32'd1);
      check("win_led", 32'(led), 32'hFF);
      check("win_score", 32'(score), 32'd2);
      check("win_level", 32'(level), 32'd2);
      check("win_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'(m_lfsr));

      // 6c: restart from WIN, reset asserted during COUNT
      btn_start = 1'b1;
      tick();
      btn_start = 1'b0;
      pat = lfsr_pat(m_lfsr);
      check("win_restart_led", 32'(led), 32'(pat));
      for (int i = 0; i < 6; i++) tick();
      check("cnt_before_rst", 32'(start_countdown), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      check("midrst_lfsr", 32'(dut.u_lfsr.lfsr_q), 32'hACE1);
      tick();
      tick();
      check_reset_outputs("midrst_hold");
      reset_n = 1'b1;
      m_lfsr = 16'hACE1;
      tick();
      m_lfsr = lfsr_step(m_lfsr);
      check_reset_outputs("post_rst");

`ifdef LED_GAME_INPUT_TIMEOUT_EN
      // 6a: no submit -> fail after 5 INPUT clocks
      btn_start = 1'b1;
      tick();
      btn_start = 1'b0;
      m_lfsr = lfsr_step(m_lfsr);
      pat = lfsr_pat(m_lfsr);
      sw = pat;
      show_to_input(pat);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("to_wait", 32'(fail_flag), 32'd0);
      end
      tick();
      check("to_fail", 32'(fail_flag), 32'd1);
      check("to_over", 32'(game_over), 32'd1);
      check("to_led", 32'(led), 32'(pat));

      // 6b: submit on the 5th clock beats the timeout
      btn_start = 1'b1;
      tick();
      btn_start = 1'b0;
      show_to_input(pat);
      for (int i = 0; i < 4; i++) tick();
      btn_submit = 1'b1;
      tick();
      btn_submit = 1'b0;
      check("to_race_nofail", 32'(fail_flag), 32'd0);
      tick();
      check("to_race_pass", 32'(pass_flag), 32'd1);
      check("to_race_fail", 32'(fail_flag), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
